// File: rtl/pattern_sender.sv
`default_nettype none
// ============================================================================
// Module      : pattern_sender
// Description : Serial transmitter that shifts a stored test pattern out,
//               LSB first, on a three-wire link (dataIn / dataClk / dataEn).
//               The transfer is framed by active-low dataEn. dataIn changes
//               only while dataClk is low, so it is stable for a full half
//               period on each side of every rising edge. An optional corrupt
//               request inverts one chosen bit of the frame, so a downstream
//               detector's mismatch path can be exercised.
//
// Ports       : clk      in   system clock, rising edge
//               reset    in   synchronous active-high reset
//               start    in   transfer request, sampled only in IDLE
//               corrupt  in   sampled with start; inverts bit CORRUPT_BIT
//               dataIn   out  serial data
//               dataClk  out  serial clock
//               dataEn   out  frame enable, active low
//               busy     out  high while a frame is in progress
//               done     out  one-cycle pulse when a frame completes
//
// Revision    : 1.0  initial release
// ============================================================================
module pattern_sender #(
    parameter int                        PATTERN_LENGTH = 64,
    parameter logic [PATTERN_LENGTH-1:0] PATTERN        =
        64'b0101011101001010101101011101111011101101010100010111100110000100,
    parameter int                        HALF_PERIOD    = 16,
    parameter int                        CORRUPT_BIT    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic corrupt,
    output logic dataIn,
    output logic dataClk,
    output logic dataEn,
    output logic busy,
    output logic done
);

    // One extra index bit so the "last bit" comparison never relies on wrap.
    localparam int c_idxWidth   = $clog2(PATTERN_LENGTH) + 1;
    localparam int c_phaseWidth = $clog2(HALF_PERIOD);

    localparam logic [c_idxWidth-1:0]   c_lastIdx    = c_idxWidth'(PATTERN_LENGTH - 1);
    localparam logic [c_idxWidth-1:0]   c_corruptIdx = c_idxWidth'(CORRUPT_BIT);
    localparam logic [c_phaseWidth-1:0] c_phaseLast  = c_phaseWidth'(HALF_PERIOD - 1);

    localparam logic [1:0] c_stIdle  = 2'd0;
    localparam logic [1:0] c_stLow   = 2'd1;
    localparam logic [1:0] c_stHigh  = 2'd2;
    localparam logic [1:0] c_stTrail = 2'd3;

    logic [1:0]              r_state;
    logic [c_phaseWidth-1:0] r_phase;
    logic [c_idxWidth-1:0]   r_bitIdx;
    logic                    r_corruptFlag;

    // Bit value actually transmitted for a given index. A shift is used
    // instead of a direct part-select so the index may be wider than the
    // pattern's natural address width.
    function automatic logic bitValue(input logic [c_idxWidth-1:0] idx,
                                      input logic                  flag);
        logic [PATTERN_LENGTH-1:0] shifted;
        shifted = PATTERN >> idx;
        return shifted[0] ^ (flag && (idx == c_corruptIdx));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_stIdle;
            r_phase       <= '0;
            r_bitIdx      <= '0;
            r_corruptFlag <= 1'b0;
            dataIn        <= 1'b0;
            dataClk       <= 1'b0;
            dataEn        <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_stIdle: begin
                    if (start) begin
                        // corrupt is used directly for bit 0 because the
                        // latched flag only becomes visible next cycle.
                        r_corruptFlag <= corrupt;
                        r_bitIdx      <= '0;
                        r_phase       <= '0;
                        dataIn        <= bitValue('0, corrupt);
                        dataEn        <= 1'b0;
                        busy          <= 1'b1;
                        r_state       <= c_stLow;
                    end
                end

                c_stLow: begin
                    if (r_phase == c_phaseLast) begin
                        r_phase <= '0;
                        dataClk <= 1'b1;
                        r_state <= c_stHigh;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                c_stHigh: begin
                    if (r_phase == c_phaseLast) begin
                        r_phase <= '0;
                        dataClk <= 1'b0;
                        if (r_bitIdx < c_lastIdx) begin
                            // New data is launched on the falling edge.
                            r_bitIdx <= r_bitIdx + 1'b1;
                            dataIn   <= bitValue(r_bitIdx + 1'b1, r_corruptFlag);
                            r_state  <= c_stLow;
                        end else begin
                            r_state  <= c_stTrail;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                c_stTrail: begin
                    // Last bit is held through a final low half period
                    // before the frame closes.
                    if (r_phase == c_phaseLast) begin
                        r_phase <= '0;
                        dataEn  <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dataIn  <= 1'b0;
                        r_state <= c_stIdle;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_stIdle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_sender
// Description : Directed self-checking bench for pattern_sender, configured
//               with an 8-bit pattern (8'b10110010), half period 8 and
//               corrupt index 5. With T the edge that samples start, the
//               value observed just after edge T+k-1 is the "T+k" value:
//               first dataClk rise at T+9, done at T+137, dataEn low over
//               T+1..T+136.
//
// Revision    : 1.0  initial release
// ============================================================================
module tb_pattern_sender;

    localparam int          c_n       = 8;
    localparam int          c_h       = 8;
    localparam logic [7:0]  c_pattern = 8'b10110010;
    localparam int          c_doneK   = 2 * c_h * c_n + c_h + 1;   // 137

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic corrupt;
    logic dataIn;
    logic dataClk;
    logic dataEn;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    pattern_sender #(
        .PATTERN_LENGTH (c_n),
        .PATTERN        (c_pattern),
        .HALF_PERIOD    (c_h),
        .CORRUPT_BIT    (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .corrupt (corrupt),
        .dataIn  (dataIn),
        .dataClk (dataClk),
        .dataEn  (dataEn),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".dataEn"},  {31'd0, dataEn},  32'd1);
        check({tag, ".dataClk"}, {31'd0, dataClk}, 32'd0);
        check({tag, ".dataIn"},  {31'd0, dataIn},  32'd0);
        check({tag, ".busy"},    {31'd0, busy},    32'd0);
        check({tag, ".done"},    {31'd0, done},    32'd0);
    endtask

    // One full frame with a single start pulse, every output checked each
    // cycle against the frame timing. 'noise' adds start pulses mid-frame.
    task automatic runFrame(input string tag, input logic corr,
                            input logic [7:0] expBits, input bit noise);
        int         doneCount = 0;
        int         riseCount = 0;
        logic       prevClk   = 1'b0;
        logic [7:0] got       = '0;
        logic       expEn, expClk, expIn;
        int         idx;
        start   = 1'b1;
        corrupt = corr;
        tick();                       // observing T+1
        start   = 1'b0;
        corrupt = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            if (k > 1) tick();
            expEn  = (k <= c_doneK - 1) ? 1'b0 : 1'b1;
            expClk = (k <= 2 * c_h * c_n) ? (((k - 1) / c_h) % 2 == 1) : 1'b0;
            idx    = (k - 1) / (2 * c_h);
            if (idx > c_n - 1) idx = c_n - 1;
            expIn  = (k <= c_doneK - 1) ? expBits[idx] : 1'b0;
            check({tag, ".dataEn"},  {31'd0, dataEn},  {31'd0, expEn});
            check({tag, ".busy"},    {31'd0, busy},    {31'd0, ~expEn});
            check({tag, ".dataClk"}, {31'd0, dataClk}, {31'd0, expClk});
            check({tag, ".dataIn"},  {31'd0, dataIn},  {31'd0, expIn});
            check({tag, ".done"},    {31'd0, done},    {31'd0, (k == c_doneK)});
            if (dataClk && !prevClk) begin
                if (riseCount == 0) check({tag, ".firstRise"}, k, 9);
                if (riseCount < 8) got[riseCount] = dataIn;
                riseCount++;
            end
            prevClk = dataClk;
            if (done) doneCount++;
            start = (noise && (k == 20 || k == 50)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({tag, ".rises"},     riseCount, 8);
        check({tag, ".bits"},      {24'd0, got}, {24'd0, expBits});
        check({tag, ".doneCount"}, doneCount, 1);
    endtask

    initial begin
        int doneCount;

        reset   = 1'b1;
        start   = 1'b0;
        corrupt = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset, with corrupt toggling but no start.
        for (int c = 0; c < 20; c++) begin
            corrupt = c[0];
            tick();
            checkIdle("idle");
        end
        corrupt = 1'b0;

        // Clean frame: rises sample 0,1,0,0,1,1,0,1.
        runFrame("clean", 1'b0, 8'b10110010, 1'b0);
        tick();
        checkIdle("postClean");

        // Corrupted frame: bit 5 inverted.
        runFrame("corrupt", 1'b1, 8'b10010010, 1'b0);
        tick();
        checkIdle("postCorrupt");

        // Next frame without corrupt must not inherit the flag.
        runFrame("flagCleared", 1'b0, 8'b10110010, 1'b0);

        // Start pulses during a frame are ignored.
        runFrame("ignoreStart", 1'b0, 8'b10110010, 1'b1);
        tick();
        checkIdle("postIgnore");

        // Reset mid-transfer, asserted so that it is sampled at edge T+40.
        start   = 1'b1;
        corrupt = 1'b1;
        tick();                       // T+1
        start   = 1'b0;
        corrupt = 1'b0;
        check("rst.preEn", {31'd0, dataEn}, 32'd0);
        for (int k = 2; k <= 40; k++) tick();
        reset = 1'b1;
        tick();                       // T+41
        checkIdle("rst.t41");
        reset = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (done) doneCount++;
        end
        check("rst.noDone", doneCount, 0);
        checkIdle("rst.after");
        // Corrupt flag must have been cleared by the reset as well.
        runFrame("afterReset", 1'b0, 8'b10110010, 1'b0);
        tick();

        // Back-to-back frames with start held: one-cycle dataEn gap.
        start     = 1'b1;
        doneCount = 0;
        tick();                       // k = 1
        for (int k = 2; k <= 300; k++) begin
            tick();
            if (done) doneCount++;
            if (k == c_doneK) begin
                check("b2b.done1",  {31'd0, done},   32'd1);
                check("b2b.gapEn",  {31'd0, dataEn}, 32'd1);
            end
            if (k == c_doneK + 1) begin
                check("b2b.reEn",   {31'd0, dataEn}, 32'd0);
                check("b2b.reBusy", {31'd0, busy},   32'd1);
                check("b2b.reDone", {31'd0, done},   32'd0);
                check("b2b.reBit0", {31'd0, dataIn}, 32'd0);
                start = 1'b0;
            end
            if (k == 2 * c_doneK) check("b2b.done2", {31'd0, done}, 32'd1);
        end
        check("b2b.doneCount", doneCount, 2);
        checkIdle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
